// File: rtl/fpu_pkg.sv
// fpu_pkg: shared binary32 types, constants and operand classification
package fpu_pkg;
  localparam int BIAS = 127;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  typedef struct packed {
    logic s;
    logic [7:0] e;
    logic [22:0] m;
  } fp32_t;
  typedef enum logic [2:0] {ZERO, NORM, INF, QNAN, SNAN} fclass_t;
  typedef struct packed {
    logic nv;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;
  function automatic fclass_t classify(input fp32_t x);
    return x.e == 8'd0 ? ZERO : x.e != 8'hFF ? NORM : x.m == '0 ? INF : x.m[22] ? QNAN : SNAN;
  endfunction
endpackage

// File: rtl/fp32_round.sv
// fp32_round: normalise a 48-bit mantissa product, round to nearest even, classify
module fp32_round
  import fpu_pkg::*;
(
  input  logic              s,
  input  logic signed [9:0] e,
  input  logic [47:0]       p,
  output logic [31:0]       y,
  output fflags_t           flags
);
  logic hi, g, r, st, up, ovf, unf;
  logic [23:0] m;
  logic [24:0] mr;
  logic [22:0] frac;
  logic signed [9:0] ef;
  always_comb begin
    hi = p[47];
    m = hi ? p[47:24] : p[46:23];
    g = hi ? p[23] : p[22];
    r = hi ? p[22] : p[21];
    st = hi ? |p[21:0] : |p[20:0];
    up = g & (r | st | m[0]);
    mr = {1'b0, m} + {24'd0, up};
    frac = mr[24] ? mr[23:1] : mr[22:0];
    ef = e + {9'd0, hi} + {9'd0, mr[24]};
    ovf = ef >= 10'sd255;
    unf = ef <= 10'sd0;
    y = ovf ? {s, 8'hFF, 23'd0} : unf ? {s, 31'd0} : {s, ef[7:0], frac};
    flags.nv = 1'b0;
    flags.of = ovf;
    flags.uf = unf;
    flags.nx = ovf | unf | g | r | st;
  end
endmodule

// File: rtl/fmul_pipe.sv
// fmul_pipe: pipelined binary32 multiplier with valid/ready handshake, RNE and flags
module fmul_pipe
  import fpu_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x1,
  input  logic [31:0]      x2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      y,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags
);
  typedef struct packed {
    logic v;
    logic [TAG_W-1:0] tag;
    logic sp;
    logic [31:0] sy;
    fflags_t sf;
    logic s;
    logic [9:0] e;
    logic [47:0] p;
  } stage_t;
  stage_t pipe [LATENCY-1];
  stage_t nxt, last;
  fp32_t a, b;
  fclass_t ca, cb;
  logic nan, anyinf, anyzero, advance;
  logic [31:0] ry;
  fflags_t rf;
  assign a = x1;
  assign b = x2;
  assign ca = classify(a);
  assign cb = classify(b);
  assign advance = out_ready | ~out_valid;
  assign in_ready = advance;
  assign last = pipe[LATENCY-2];
  always_comb begin
    nan = ca inside {QNAN, SNAN} || cb inside {QNAN, SNAN};
    anyinf = ca == INF || cb == INF;
    anyzero = ca == ZERO || cb == ZERO;
    nxt = '0;
    nxt.v = in_valid;
    nxt.tag = in_tag;
    nxt.s = a.s ^ b.s;
    nxt.e = {2'b0, a.e} + {2'b0, b.e} - 10'(BIAS);
    nxt.p = 48'({1'b1, a.m}) * 48'({1'b1, b.m});
    nxt.sp = nan | anyinf | anyzero;
    nxt.sy = nan || (anyinf && anyzero) ? CANON_NAN : anyinf ? {nxt.s, 8'hFF, 23'd0} : {nxt.s, 31'd0};
    nxt.sf.nv = ca == SNAN || cb == SNAN || (!nan && anyinf && anyzero);
  end
  fp32_round u_round (.s(last.s), .e(last.e), .p(last.p), .y(ry), .flags(rf));
  // Stage 0 registers the raw product; later entries are pure delay for retiming.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY - 1; i++) pipe[i] <= '0;
      out_valid <= 1'b0;
      y <= '0;
      flags <= '0;
      out_tag <= '0;
    end else if (advance) begin
      pipe[0] <= nxt;
      for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
      out_valid <= last.v;
      y <= last.sp ? last.sy : ry;
      flags <= last.sp ? last.sf : rf;
      out_tag <= last.tag;
    end
  end
endmodule
